// File: rtl/bcd_block_loader.sv
// BCD triplet to byte loader: reverse double-dabble conversion, packing
// NB bytes MSB-first into one block handed off over valid/ready.
module bcd_block_loader #(
  parameter int NB = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            digit_valid,
  output logic            digit_ready,
  input  logic [3:0]      hunds,
  input  logic [3:0]      tens,
  input  logic [3:0]      units,
  output logic            err,
  output logic [4:0]      byte_count,
  output logic [0:8*NB-1] block,
  output logic            block_valid,
  input  logic            block_ready
);

  localparam int AW = $clog2(8*NB);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    STORE,
    FULL
  } state_e;

  state_e           state_q, state_d;
  logic [11:0]      bcd_q;
  logic [7:0]       bin_q;
  logic [2:0]       iter_q;
  logic [4:0]       cnt_q;
  logic [0:8*NB-1]  blk_q;
  logic             err_q;

  logic             bad;
  logic [19:0]      sh;
  logic [19:0]      dd;
  logic [AW-1:0]    base;

  // Out of range for a byte, or not BCD at all
  assign bad = (hunds > 4'd9) | (tens > 4'd9) | (units > 4'd9)
             | (hunds > 4'd2)
             | ((hunds == 4'd2) & (tens > 4'd5))
             | ((hunds == 4'd2) & (tens == 4'd5) & (units > 4'd5));

  always_comb begin
    sh = {bcd_q, bin_q} >> 1;
    dd = sh;
    for (int i = 0; i < 3; i++) begin
      if (sh[8+4*i +: 4] >= 4'd8)
        dd[8+4*i +: 4] = sh[8+4*i +: 4] - 4'd3;
    end
  end

  assign base = AW'({cnt_q, 3'b000});

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (digit_valid && !bad) state_d = CONV;
      CONV:  if (iter_q == 3'd7) state_d = STORE;
      STORE: state_d = (cnt_q == 5'(NB-1)) ? FULL : IDLE;
      FULL:  if (block_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    digit_ready = (state_q == IDLE);
    block_valid = (state_q == FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      iter_q <= '0;
      cnt_q  <= '0;
      blk_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) & digit_valid & bad;
      unique case (state_q)
        IDLE: begin
          if (digit_valid && !bad) begin
            bcd_q  <= {hunds, tens, units};
            bin_q  <= '0;
            iter_q <= '0;
          end
        end
        CONV: begin
          {bcd_q, bin_q} <= dd;
          iter_q         <= iter_q + 3'd1;
        end
        STORE: begin
          blk_q[base +: 8] <= bin_q;
          cnt_q            <= cnt_q + 5'd1;
        end
        FULL: begin
          if (block_ready) cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign err        = err_q;
  assign byte_count = cnt_q;
  assign block      = blk_q;

endmodule

// File: doc/bcd_block_loader.md
# bcd_block_loader

Sequential input-side loader for the AES demonstrator: the inverse of the byte→BCD display path. It accepts one byte at a time as three BCD digits (hundreds, tens, units), converts each to binary with an iterative reverse double-dabble, and packs 16 bytes MSB-first into a 128-bit block. The block then feeds the cipher's plaintext/key input through a valid/ready handshake.

## Interface
- NB, 16, bytes per block; block width is 8*NB bits.
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high; clock clk
- digit_valid  in  1  digit triplet offered
- digit_ready  out  1  loader can accept a triplet (high only in IDLE)
- hunds  in  4  BCD hundreds digit
- tens  in  4  BCD tens digit
- units  in  4  BCD units digit
- err  out  1  one-cycle pulse: accepted triplet was invalid and was dropped
- byte_count  out  5  bytes stored in the current block (0..NB)
- block  out  8*NB, [0:8*NB-1]  assembled block; byte k occupies bits [8k:8k+7]
- block_valid  out  1  block complete and held stable
- block_ready  in  1  consumer takes the block

## Operation
- States: IDLE, CONV, STORE, FULL.
- IDLE: digit_ready=1. The accept edge is any edge with digit_valid=1 in IDLE.
  - Invalid triplet: any digit >9, or value >255 (hunds>2; hunds=2 & tens>5; hunds=2 & tens=5 & units>5). Pulse err for one cycle, stay in IDLE, leave byte_count and block unchanged.
  - Valid triplet: latch the 12-bit BCD {hunds,tens,units}, clear the 8-bit binary register, set iter=0, go to CONV.
- CONV: runs 8 iterations, one per cycle. Each iteration:
  - shift the 20-bit {bcd,bin} register right by 1;
  - then subtract 3 from every BCD nibble that is ≥8.
  - After the 8th iteration, bin holds the byte; go to STORE.
- STORE: write bin to block[8*byte_count +: 8], MSB-first order, then increment byte_count.
  - If the new byte_count == NB, go to FULL; otherwise go to IDLE.
- FULL: block_valid=1 and block is stable. On an edge with block_ready=1: byte_count←0, go to IDLE. The block register is not cleared; the next block overwrites it byte by byte.
- digit_valid is ignored outside IDLE. No triplet is buffered.
- Reset values: state IDLE, digit_ready=1, err=0, block_valid=0, byte_count=0, block=0, internal registers 0.
- Reset mid-operation (CONV, STORE or FULL) discards the partial byte and the block, and returns all outputs to their reset values on the next edge.

## Timing
- digit_ready and block_valid decode state directly. err is registered.
- Accept edge at cycle T. CONV occupies T+1..T+8, STORE is at T+9, and the byte is visible in block and byte_count after edge T+9.
- digit_ready returns high at T+10 unless the loader enters FULL. Peak throughput is one byte per 10 cycles.
- Error path: err=1 during cycle T+1 only. digit_ready stays high, so a new triplet can be accepted at edge T+1.
- block_valid rises the cycle after the STORE of byte NB-1.
- Handshake completes on the first edge with block_valid & block_ready. digit_ready is high the following cycle.
- block_ready held high before FULL has no effect.
- Simultaneous reset and handshake: reset wins.

## Test plan
- Reset, then digits 2,5,5 -> after 10 cycles block[0:7]=8'hFF, byte_count=1, err stays 0. Repeat with 0,0,0 -> block[8:15]=8'h00.
- Feed 16 triplets encoding 00,11,22,...,FF (e.g. 0,0,0; 0,1,7; 0,3,4; ... 2,5,5) -> block=128'h00112233445566778899aabbccddeeff, block_valid=1, digit_ready=0.
- Invalid inputs 2,5,6 / 3,0,0 / 1,A,0 -> err pulse for exactly 1 cycle each, byte_count unchanged, next valid triplet accepted one cycle later.
- In FULL: hold block_ready=0 for 20 cycles while driving digit_valid=1 -> block stable, no acceptance. Then raise block_ready -> byte_count=0, digit_ready=1 next cycle.
- Assert reset at T+4 of a conversion after 5 stored bytes -> byte_count=0, block=0, block_valid=0, digit_ready=1.
- Random sweep of all 256 valid byte values -> converted byte equals 100*hunds+10*tens+units; 10-cycle cadence holds under back-to-back digit_valid.
